// File: rtl/axi_to_mem_pkg.sv
// Shared definitions for the AXI-to-memory bridge: AXI response codes, response
// merging and the packed B-beat width.
package axi_to_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        StIdle,
        StFull
    } b_state_e;

    // Worst response wins: DECERR > SLVERR > OKAY.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        if (a == RESP_DECERR || b == RESP_DECERR) begin
            return RESP_DECERR;
        end else if (a == RESP_SLVERR || b == RESP_SLVERR) begin
            return RESP_SLVERR;
        end else begin
            return RESP_OKAY;
        end
    endfunction

    function automatic int unsigned b_width(input int unsigned id_w, input int unsigned user_w);
        return id_w + 2 + user_w;
    endfunction

endpackage

// File: rtl/axi_to_mem_id_fifo.sv
// Circular FIFO holding {id, user} per outstanding AW; Depth must be a power of two
// so the pointers wrap naturally.
module axi_to_mem_id_fifo #(
    parameter int unsigned Width = 5,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/axi_to_mem_b_gen.sv
// B-channel generator: merges per-beat completions into one response per burst.
// Define AXI_TO_MEM_B_GEN_DECERR_EN to return DECERR for decode errors.
module axi_to_mem_b_gen
    import axi_to_mem_pkg::*;
#(
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned UserWidth = 1,
    parameter int unsigned MaxTxn    = 8
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         aw_valid_i,
    output logic                                         aw_ready_o,
    input  logic [IdWidth-1:0]                           aw_id_i,
    input  logic [((UserWidth > 0) ? UserWidth : 1)-1:0] aw_user_i,
    input  logic                                         done_valid_i,
    output logic                                         done_ready_o,
    input  logic                                         done_last_i,
    input  logic                                         done_err_i,
    input  logic                                         done_dec_i,
    output logic                                         valid_o,
    input  logic                                         ready_i,
    output logic [b_width(IdWidth, UserWidth)-1:0]       data_o
);

    localparam int unsigned UserW  = (UserWidth > 0) ? UserWidth : 1;
    localparam int unsigned BWidth = b_width(IdWidth, UserWidth);
    localparam int unsigned EntryW = IdWidth + UserW;

    b_state_e          state_q, state_d;
    logic [1:0]        acc_q, acc_d;
    logic [BWidth-1:0] data_q, data_d, load_data;
    logic [EntryW-1:0] head;
    logic [IdWidth-1:0] head_id;
    logic [UserW-1:0]  head_user;
    logic              fifo_full, fifo_empty;
    logic              push, done_fire, last_fire, b_fire;
    logic [1:0]        beat_resp, merged;

    assign aw_ready_o   = !rst_i && !fifo_full;
    assign valid_o      = !rst_i && (state_q == StFull);
    assign done_ready_o = !rst_i && !fifo_empty && (!valid_o || ready_i);
    assign push         = aw_valid_i && aw_ready_o;
    assign done_fire    = done_valid_i && done_ready_o;
    assign last_fire    = done_fire && done_last_i;
    assign b_fire       = valid_o && ready_i;

    axi_to_mem_id_fifo #(
        .Width (EntryW),
        .Depth (MaxTxn)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  ({aw_id_i, aw_user_i}),
        .pop_i   (last_fire),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_id   = head[EntryW-1 -: IdWidth];
    assign head_user = head[UserW-1:0];

`ifdef AXI_TO_MEM_B_GEN_DECERR_EN
    assign beat_resp = done_dec_i ? RESP_DECERR : (done_err_i ? RESP_SLVERR : RESP_OKAY);
`else
    // Decode errors fold into SLVERR when DECERR reporting is disabled.
    assign beat_resp = (done_dec_i || done_err_i) ? RESP_SLVERR : RESP_OKAY;
`endif

    assign merged = resp_max(acc_q, beat_resp);

    if (UserWidth > 0) begin : g_user
        assign load_data = {head_id, merged, head_user};
    end else begin : g_no_user
        assign load_data = {head_id, merged};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        data_d  = data_q;
        if (b_fire) begin
            state_d = StIdle;
        end
        if (done_fire) begin
            if (done_last_i) begin
                state_d = StFull;
                data_d  = load_data;
                acc_d   = RESP_OKAY;
            end else begin
                acc_d = merged;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            acc_q   <= RESP_OKAY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: tb/tb_axi_to_mem_b_gen.sv
// Directed self-checking bench for axi_to_mem_b_gen (IdWidth=4, UserWidth=1, MaxTxn=8).
module tb_axi_to_mem_b_gen;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       aw_valid_i;
    logic       aw_ready_o;
    logic [3:0] aw_id_i;
    logic [0:0] aw_user_i;
    logic       done_valid_i;
    logic       done_ready_o;
    logic       done_last_i;
    logic       done_err_i;
    logic       done_dec_i;
    logic       valid_o;
    logic       ready_i;
    logic [6:0] data_o;

    int checks   = 0;
    int failures = 0;

    axi_to_mem_b_gen #(
        .IdWidth   (4),
        .UserWidth (1),
        .MaxTxn    (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .aw_valid_i   (aw_valid_i),
        .aw_ready_o   (aw_ready_o),
        .aw_id_i      (aw_id_i),
        .aw_user_i    (aw_user_i),
        .done_valid_i (done_valid_i),
        .done_ready_o (done_ready_o),
        .done_last_i  (done_last_i),
        .done_err_i   (done_err_i),
        .done_dec_i   (done_dec_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_aw(input logic [3:0] id, input logic user);
        aw_valid_i = 1'b1;
        aw_id_i    = id;
        aw_user_i  = user;
        #1;
        check_eq("aw_ready", {31'd0, aw_ready_o}, 32'd1);
        tick();
        aw_valid_i = 1'b0;
    endtask

    task automatic beat(input logic last, input logic err, input logic dec);
        done_valid_i = 1'b1;
        done_last_i  = last;
        done_err_i   = err;
        done_dec_i   = dec;
        #1;
        check_eq("done_ready", {31'd0, done_ready_o}, 32'd1);
        tick();
        done_valid_i = 1'b0;
        done_last_i  = 1'b0;
        done_err_i   = 1'b0;
        done_dec_i   = 1'b0;
    endtask

    task automatic expect_b(input string tag, input logic [6:0] exp);
        check_eq({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        check_eq({tag, "_data"}, {25'd0, data_o}, {25'd0, exp});
    endtask

    task automatic take_b();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check_eq("b_cleared", {31'd0, valid_o}, 32'd0);
    endtask

    logic [6:0] exp_dec;

    initial begin
        rst_i        = 1'b1;
        aw_valid_i   = 1'b0;
        aw_id_i      = '0;
        aw_user_i    = '0;
        done_valid_i = 1'b0;
        done_last_i  = 1'b0;
        done_err_i   = 1'b0;
        done_dec_i   = 1'b0;
        ready_i      = 1'b0;
        repeat (3) tick();
        check_eq("rst_aw_ready", {31'd0, aw_ready_o}, 32'd0);
        check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
        rst_i = 1'b0;
        tick();
        check_eq("post_rst_aw_ready", {31'd0, aw_ready_o}, 32'd1);
        check_eq("post_rst_done_ready", {31'd0, done_ready_o}, 32'd0);
        check_eq("post_rst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("post_rst_data", {25'd0, data_o}, 32'd0);

        // 4-beat OKAY burst, id=3 user=1
        push_aw(4'd3, 1'b1);
        beat(1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        beat(1'b0, 1'b0, 1'b0);
        check_eq("no_b_before_last", {31'd0, valid_o}, 32'd0);
        beat(1'b1, 1'b0, 1'b0);
        expect_b("okay4", 7'h19);
        take_b();

        // Error on first beat sticks through an OKAY last beat
        push_aw(4'd5, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        expect_b("slverr", 7'h2C);
        take_b();

        // Accumulator cleared after emission
        push_aw(4'd7, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        expect_b("acc_clear", 7'h38);
        take_b();

        // Decode error on last beat
        push_aw(4'd6, 1'b1);
        beat(1'b0, 1'b0, 1'b0);
        beat(1'b1, 1'b0, 1'b1);
`ifdef AXI_TO_MEM_B_GEN_DECERR_EN
        exp_dec = 7'h37;
`else
        exp_dec = 7'h35;
`endif
        expect_b("decerr", exp_dec);
        take_b();

        // Fill the FIFO (write pointer wraps), then drain at full rate
        for (int i = 0; i < 8; i++) begin
            push_aw(4'(i), 1'(i));
        end
        check_eq("full_aw_ready", {31'd0, aw_ready_o}, 32'd0);
        ready_i      = 1'b1;
        done_valid_i = 1'b1;
        done_last_i  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_b("drain", {4'(i), 2'b00, 1'(i)});
        end
        done_valid_i = 1'b0;
        done_last_i  = 1'b0;
        #1;
        check_eq("drained_done_ready", {31'd0, done_ready_o}, 32'd0);
        check_eq("drained_aw_ready", {31'd0, aw_ready_o}, 32'd1);
        tick();
        check_eq("drained_valid", {31'd0, valid_o}, 32'd0);
        ready_i = 1'b0;

        // Backpressure: second last beat stalls, then FULL->FULL swap
        push_aw(4'd9, 1'b1);
        push_aw(4'd10, 1'b0);
        beat(1'b1, 1'b0, 1'b0);
        expect_b("stall_first", 7'h49);
        done_valid_i = 1'b1;
        done_last_i  = 1'b1;
        done_err_i   = 1'b1;
        #1;
        check_eq("stall_done_ready", {31'd0, done_ready_o}, 32'd0);
        tick();
        expect_b("stall_hold", 7'h49);
        ready_i = 1'b1;
        #1;
        check_eq("swap_done_ready", {31'd0, done_ready_o}, 32'd1);
        tick();
        expect_b("swap", 7'h54);
        done_valid_i = 1'b0;
        done_last_i  = 1'b0;
        done_err_i   = 1'b0;
        tick();
        check_eq("swap_drained", {31'd0, valid_o}, 32'd0);
        ready_i = 1'b0;

        // Completion while empty is stalled
        done_valid_i = 1'b1;
        done_last_i  = 1'b1;
        #1;
        check_eq("empty_done_ready", {31'd0, done_ready_o}, 32'd0);
        tick();
        tick();
        check_eq("empty_no_b", {31'd0, valid_o}, 32'd0);
        done_valid_i = 1'b0;
        done_last_i  = 1'b0;

        // Reset mid-burst with an error already accumulated
        push_aw(4'd1, 1'b0);
        push_aw(4'd2, 1'b0);
        push_aw(4'd3, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        rst_i = 1'b1;
        tick();
        check_eq("midrst_valid", {31'd0, valid_o}, 32'd0);
        rst_i = 1'b0;
        #1;
        check_eq("midrst_empty", {31'd0, done_ready_o}, 32'd0);
        check_eq("midrst_aw_ready", {31'd0, aw_ready_o}, 32'd1);
        push_aw(4'd12, 1'b1);
        beat(1'b1, 1'b0, 1'b0);
        expect_b("after_rst", 7'h61);
        take_b();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
